fifo_uart_tx: RTL and testbench
===============================

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 217, meaning clock cycles per UART bit (25 MHz / 115200); legal range 2..65535.
REQ-002 SHALL have port i_clk  input  1  single clock; all logic on its rising edge.
REQ-003 SHALL have port i_rst_l  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port i_enable  input  1  permits starting a new frame.
REQ-005 SHALL have port i_fifo_empty  input  1  upstream FIFO empty flag.
REQ-006 SHALL have port o_fifo_rd_en  output  1  single-cycle read request to the FIFO.
REQ-007 SHALL have port i_fifo_rd_dv  input  1  FIFO read data valid.
REQ-008 SHALL have port i_fifo_rd_data  input  8  FIFO read data, sampled when i_fifo_rd_dv is high.
REQ-009 SHALL have port o_tx_serial  output  1  UART line, idle high.
REQ-010 SHALL have port o_tx_active  output  1  high from the START state entry through the last STOP cycle.
REQ-011 SHALL have port o_tx_done  output  1  one-cycle pulse on the last cycle of the stop bit.

Function
REQ-012 SHALL implement FSM states IDLE, WAIT_DV, START, DATA, STOP (plus PARITY when configured).
REQ-013 IDLE: when i_enable=1 and i_fifo_empty=0, SHALL drive o_fifo_rd_en=1 for exactly that cycle and go to WAIT_DV; otherwise remain in IDLE with o_fifo_rd_en=0.
REQ-014 SHALL never assert o_fifo_rd_en while i_fifo_empty=1 or outside IDLE.
REQ-015 WAIT_DV: on the cycle i_fifo_rd_dv=1, SHALL capture i_fifo_rd_data into the shift register and go to START; arbitrary wait length is allowed.
REQ-016 SHALL ignore i_fifo_rd_dv in every state except WAIT_DV.
REQ-017 START: o_tx_serial=0 for CLKS_PER_BIT cycles.
REQ-018 DATA: 8 bits LSB first, each held CLKS_PER_BIT cycles; a 3-bit index selects the bit.
REQ-019 STOP: o_tx_serial=1 for CLKS_PER_BIT cycles; o_tx_done=1 on its final cycle; next state IDLE.
REQ-020 SHALL use a bit-period counter of width $clog2(CLKS_PER_BIT), counting 0..CLKS_PER_BIT-1 and wrapping to 0 at each bit boundary.
REQ-021 o_tx_serial SHALL be 1 in IDLE and WAIT_DV.
REQ-022 Deasserting i_enable mid-frame SHALL NOT abort the frame; it only blocks the next IDLE->WAIT_DV transition.
REQ-023 Back-to-back: with the FIFO non-empty and i_enable=1, the next o_fifo_rd_en SHALL assert the cycle after o_tx_done.
REQ-024 o_tx_serial, o_tx_active, and o_tx_done SHALL be registered; o_fifo_rd_en MAY be a combinational decode of IDLE.

Reset
REQ-025 While i_rst_l=0 at a clock edge, SHALL set: state=IDLE, counters=0, shift register=0, o_tx_serial=1, o_tx_active=0, o_tx_done=0, o_fifo_rd_en=0.
REQ-026 Reset asserted mid-frame SHALL force o_tx_serial high at the next edge; the interrupted byte is discarded and not re-read.

Configuration
REQ-027 When macro FIFO_UART_TX_PARITY_EN is defined, SHALL insert a PARITY state between DATA and STOP transmitting the even-parity bit (XOR of 8 data bits) for CLKS_PER_BIT cycles; frame length = 11*CLKS_PER_BIT.
REQ-028 When FIFO_UART_TX_PARITY_EN is undefined, DATA SHALL go directly to STOP; frame length = 10*CLKS_PER_BIT.

Verification (CLKS_PER_BIT=4)
REQ-029 Reset: i_rst_l=0 for 3 cycles, mid-frame -> o_tx_serial=1, o_tx_active=0, o_fifo_rd_en=0 at next edge; no frame resumes.
REQ-030 Single byte: FIFO holds 0xA5, i_enable=1 -> one rd_en pulse; line shows 0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 (4 cycles each), then 1 for 4 cycles; o_tx_done pulse at cycle 40 after START entry.
REQ-031 Empty FIFO: i_fifo_empty=1, i_enable=1 for 100 cycles -> o_fifo_rd_en never asserts; o_tx_serial stays 1.
REQ-032 Back-to-back: FIFO holds 0x00, 0xFF -> two complete frames; second rd_en the cycle after the first o_tx_done; no missing or extra bits.
REQ-033 Late data valid: i_fifo_rd_dv delayed 5 cycles after rd_en, with spurious rd_dv pulses during DATA -> frame transmits only the captured byte; spurious pulses have no effect.
REQ-034 Parity build: byte 0x07 -> parity bit 1 precedes stop; byte 0xA5 -> parity bit 0; o_tx_done at cycle 44.

Source files
------------

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pulls one byte at a time from an upstream FIFO and sends it as an
// 8N1 UART frame (start, 8 data bits LSB first, stop), idle-high line.
// Optional build macro FIFO_UART_TX_PARITY_EN adds an even-parity bit between the
// last data bit and the stop bit.
module fifo_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 217
) (
    input  logic       i_clk,
    input  logic       i_rst_l,
    input  logic       i_enable,
    input  logic       i_fifo_empty,
    output logic       o_fifo_rd_en,
    input  logic       i_fifo_rd_dv,
    input  logic [7:0] i_fifo_rd_data,
    output logic       o_tx_serial,
    output logic       o_tx_active,
    output logic       o_tx_done
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

`ifdef FIFO_UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT_DV = 3'd1,
        START   = 3'd2,
        DATA    = 3'd3,
        PARITY  = 3'd4,
        STOP    = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT_DV = 3'd1,
        START   = 3'd2,
        DATA    = 3'd3,
        STOP    = 3'd5
    } state_t;
`endif

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             serial_d;
    logic             active_d;
    logic             done_d;
    logic             bit_end;

    // Last cycle of the current bit period.
    assign bit_end = (cnt_q == CNT_LAST);

    // Read request is a decode of IDLE; held off while reset is asserted.
    assign o_fifo_rd_en = i_rst_l && (state_q == IDLE) && i_enable && !i_fifo_empty;

    // State, counters, byte buffer and registered line outputs.
    always_ff @(posedge i_clk) begin
        if (!i_rst_l) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            o_tx_serial <= 1'b1;
            o_tx_active <= 1'b0;
            o_tx_done   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            o_tx_serial <= serial_d;
            o_tx_active <= active_d;
            o_tx_done   <= done_d;
        end
    end

    // Next-state logic; outputs are decoded from the next state so they line up
    // with the state register.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;

        case (state_q)
            IDLE: begin
                if (i_enable && !i_fifo_empty) begin
                    state_d = WAIT_DV;
                end
            end
            WAIT_DV: begin
                if (i_fifo_rd_dv) begin
                    shift_d = i_fifo_rd_data;
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (idx_q == 3'd7) begin
`ifdef FIFO_UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                idx_d   = '0;
                state_d = IDLE;
            end
        endcase

        case (state_d)
            START:   serial_d = 1'b0;
            DATA:    serial_d = shift_d[idx_d];
`ifdef FIFO_UART_TX_PARITY_EN
            PARITY:  serial_d = ^shift_d;
`endif
            default: serial_d = 1'b1;
        endcase

        active_d = (state_d != IDLE) && (state_d != WAIT_DV);
        done_d   = (state_d == STOP) && (cnt_d == CNT_LAST);
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: randomized bench for fifo_uart_tx with CLKS_PER_BIT=4.
// A FIFO/data-valid driver feeds bytes; a frame-timeline model predicts the
// line, active, done and read-request values every cycle.
`timescale 1ns/1ps
module tb_fifo_uart_tx;

    localparam int unsigned CLKS = 4;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = CLKS * NBITS;

    logic       clk = 1'b0;
    logic       rst_l = 1'b0;
    logic       enable = 1'b0;
    logic       fifo_empty = 1'b1;
    logic       rd_en;
    logic       rd_dv = 1'b0;
    logic [7:0] rd_data = 8'h00;
    logic       tx_serial;
    logic       tx_active;
    logic       tx_done;

    fifo_uart_tx #(.CLKS_PER_BIT(CLKS)) dut (
        .i_clk          (clk),
        .i_rst_l        (rst_l),
        .i_enable       (enable),
        .i_fifo_empty   (fifo_empty),
        .o_fifo_rd_en   (rd_en),
        .i_fifo_rd_dv   (rd_dv),
        .i_fifo_rd_data (rd_data),
        .o_tx_serial    (tx_serial),
        .o_tx_active    (tx_active),
        .o_tx_done      (tx_done)
    );

    always #5 clk = ~clk;

    // Reference model state: frame timeline position (-1 = no frame on the line).
    int         frame_pos = -1;
    logic [7:0] frame_byte = 8'h00;
    logic [7:0] pending = 8'h00;
    bit         waiting = 1'b0;
    int         dv_wait = 0;
    logic [7:0] fifo_q[$];

    // Stimulus knobs.
    int  rst_hold = 0;
    bit  en_level = 1'b1;
    bit  en_rand = 1'b0;
    bit  spurious = 1'b0;
    bit  rand_rst = 1'b0;
    int  dly_lo = 0;
    int  dly_hi = 0;

    // Bookkeeping.
    int n_vec = 0;
    int n_err = 0;
    int act_rd = 0;
    int act_done = 0;
    int exp_done = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Line level at a given cycle offset from START entry for a given byte.
    function automatic logic exp_bit(input logic [7:0] b, input int pos);
        int k;
        k = pos / CLKS;
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
`ifdef FIFO_UART_TX_PARITY_EN
        if (k == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    // One clock cycle: drive inputs, check outputs against the model, advance the model.
    task automatic step();
        logic exp_rd;
        logic exp_ser;
        logic exp_act;
        logic exp_dn;
        @(negedge clk);
        if (rand_rst && rst_hold == 0 && $urandom_range(0, 199) == 0)
            rst_hold = $urandom_range(1, 3);
        rst_l      = (rst_hold == 0);
        fifo_empty = (fifo_q.size() == 0);
        enable     = en_rand ? 1'($urandom_range(0, 1)) : en_level;
        if (waiting && dv_wait == 0) begin
            rd_dv   = 1'b1;
            rd_data = pending;
        end else if (spurious && !waiting && $urandom_range(0, 2) == 0) begin
            rd_dv   = 1'b1;
            rd_data = 8'($urandom);
        end else begin
            rd_dv   = 1'b0;
            rd_data = 8'($urandom);
        end
        #1;
        exp_rd = rst_l && enable && !fifo_empty && !waiting && (frame_pos < 0);
        if (frame_pos >= 0) begin
            exp_ser = exp_bit(frame_byte, frame_pos);
            exp_act = 1'b1;
            exp_dn  = (frame_pos == FRAME - 1);
        end else begin
            exp_ser = 1'b1;
            exp_act = 1'b0;
            exp_dn  = 1'b0;
        end
        check_eq("rd_en", 32'(rd_en), 32'(exp_rd));
        check_eq("tx_serial", 32'(tx_serial), 32'(exp_ser));
        check_eq("tx_active", 32'(tx_active), 32'(exp_act));
        check_eq("tx_done", 32'(tx_done), 32'(exp_dn));
        if (rd_en === 1'b1) act_rd++;
        if (tx_done === 1'b1) act_done++;
        if (exp_dn) exp_done++;

        if (!rst_l) begin
            frame_pos = -1;
            waiting   = 1'b0;
            rst_hold--;
        end else if (frame_pos >= 0) begin
            frame_pos++;
            if (frame_pos == FRAME) frame_pos = -1;
        end else if (waiting) begin
            if (dv_wait == 0) begin
                waiting    = 1'b0;
                frame_pos  = 0;
                frame_byte = pending;
            end else begin
                dv_wait--;
            end
        end else if (exp_rd) begin
            pending = fifo_q.pop_front();
            waiting = 1'b1;
            dv_wait = $urandom_range(dly_lo, dly_hi);
        end
    endtask

    // Run until the model has drained the FIFO and the line is idle, within a budget.
    task automatic run_idle(input int budget);
        int n;
        n = 0;
        while ((frame_pos >= 0 || waiting || fifo_q.size() > 0 || rst_hold > 0) && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout @%0t: ran %0d cycles, required idle within %0d", $time, n, budget);
        end
        repeat (2) step();
    endtask

    initial begin
        int rd0;
        int dn0;
        int n;

        rst_l = 1'b0;
        repeat (3) @(posedge clk);

        // Reset held three cycles with a full request condition present.
        fifo_q.push_back(8'h11);
        rst_hold = 3;
        en_level = 1'b1;
        repeat (3) step();
        void'(fifo_q.pop_front());
        en_level = 1'b1;

        // Single byte 0xA5, immediate data valid.
        rd0 = act_rd;
        dn0 = act_done;
        fifo_q.push_back(8'hA5);
        dly_lo = 0; dly_hi = 0;
        run_idle(200);
        check_eq("a5_rd_pulses", 32'(act_rd - rd0), 32'd1);
        check_eq("a5_done_pulses", 32'(act_done - dn0), 32'd1);

        // Empty FIFO with enable high for 100 cycles.
        rd0 = act_rd;
        repeat (100) step();
        check_eq("empty_rd_pulses", 32'(act_rd - rd0), 32'd0);

        // Back-to-back bytes, including an odd-parity-weight byte.
        dn0 = act_done;
        fifo_q.push_back(8'h00);
        fifo_q.push_back(8'hFF);
        fifo_q.push_back(8'h07);
        run_idle(400);
        check_eq("b2b_done_pulses", 32'(act_done - dn0), 32'd3);

        // Late data valid with spurious valid pulses outside WAIT_DV.
        spurious = 1'b1;
        dly_lo = 5; dly_hi = 5;
        fifo_q.push_back(8'h3C);
        fifo_q.push_back(8'hC3);
        run_idle(400);

        // Reset in the middle of a frame; the interrupted byte is not re-read.
        spurious = 1'b0;
        dly_lo = 1; dly_hi = 1;
        rd0 = act_rd;
        fifo_q.push_back(8'h5A);
        fifo_q.push_back(8'h81);
        n = 0;
        while (frame_pos != 12 && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) begin
            n_vec++;
            n_err++;
            $display("FAIL midframe_wait @%0t: frame never reached offset 12", $time);
        end
        en_level = 1'b0;
        rst_hold = 3;
        repeat (60) step();
        check_eq("reset_rd_pulses", 32'(act_rd - rd0), 32'd1);
        en_level = 1'b1;
        run_idle(300);
        check_eq("after_reset_rd_pulses", 32'(act_rd - rd0), 32'd2);

        // Randomized traffic: random enable, delays, spurious valids and resets.
        en_rand  = 1'b1;
        spurious = 1'b1;
        rand_rst = 1'b1;
        dly_lo = 0; dly_hi = 6;
        for (int i = 0; i < 40; i++) fifo_q.push_back(8'($urandom));
        run_idle(10000);
        rand_rst = 1'b0;
        en_rand  = 1'b0;
        repeat (5) step();
        check_eq("total_done_pulses", 32'(act_done), 32'(exp_done));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global guard against a stalled run.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
